game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Top-level game controller. Generates the 8-bit game_state code that drives the countdown timer and the puzzle modules.
- Selects and latches the initial BCD time loaded by the countdown timer.
- Monitors the timer digits, per-module solved flags and per-module strike pulses, and decides the outcome: defused or exploded.
- Sits between the push-button/switch inputs and every game-state consumer.

Parameters:
- NUM_MODULES, 4, number of puzzle modules; width of solved/strike vectors (1..8).
- MAX_STRIKES, 3, strike count that causes an explosion (1..15).
- GUARD_CYCLES, 4, cycles after entering RUNNING during which timer-zero detection is masked while the timer loads (≥2).

Ports:
- clk  in  1  on-board 50 MHz clock
- reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle pulse, debounced upstream; starts a game or returns from an end state
- time_sel  in  2  difficulty select, sampled on start in IDLE
- value_three  in  4  timer BCD hundreds digit
- value_two  in  4  timer BCD tens digit
- value_one  in  4  timer BCD units digit
- solved  in  NUM_MODULES  per-module solved level
- strike  in  NUM_MODULES  per-module single-cycle strike pulse
- game_state  out  8  state code: 8'h00 IDLE, 8'h10 RUNNING, 8'h20 DEFUSED, 8'h30 EXPLODED
- init_time  out  12  BCD {hundreds, tens, units} initial time
- strike_count  out  4  accumulated strikes
- solved_mask  out  NUM_MODULES  sticky solved flags

Behaviour:
- Clocking and reset:
  - All outputs are registered; every update happens on posedge clk.
  - When reset==0 at a clock edge: state=IDLE, game_state=8'h00, init_time=12'h300, strike_count=0, solved_mask=0, guard counter=0.
  - Reset mid-game aborts to IDLE on that same edge.
- init_time decode (applied on a start pulse in IDLE):
  - 00 → 12'h300
  - 01 → 12'h200
  - 10 → 12'h100
  - 11 → 12'h060
  - init_time holds its value at all other times.
- IDLE:
  - On start: load init_time, clear strike_count and solved_mask, load guard=GUARD_CYCLES, go to RUNNING.
  - game_state reads 8'h10 on the cycle after the start pulse.
- RUNNING:
  - guard decrements each cycle until it reaches 0.
  - solved_mask |= solved (sticky; a deasserting solved input never clears a bit).
  - strike_count += popcount(strike) each cycle, saturating at 15.
  - Multiple strike bits in one cycle each count.
- Exit conditions, evaluated on the updated values of the same cycle, in priority order:
  - (a) next strike_count ≥ MAX_STRIKES → EXPLODED.
  - (b) guard==0 and value_three, value_two, value_one all 0 → EXPLODED.
  - (c) next solved_mask all ones → DEFUSED.
  - Otherwise stay in RUNNING.
  - Explosion beats defusal when both occur in the same cycle.
  - start in RUNNING is ignored.
- DEFUSED / EXPLODED:
  - Hold the state; strike_count and solved_mask freeze; strike and solved inputs are ignored.
  - On start: go to IDLE. Do not start a new game on the same pulse.
- Latency:
  - Any input event is reflected in game_state one clock later.
- Width rules:
  - popcount is NUM_MODULES-wide; strike sum uses saturating 4-bit addition.
  - Timer digits are treated as BCD but compared only for zero; the controller never writes them.
- Illegal encodings:
  - Any unreachable internal state recovers to IDLE with game_state=8'h00 on the next clock.

Test Plan:
1. Reset low 2 cycles, then high; time_sel=01; start pulse → game_state 8'h00→8'h10 one cycle after start; init_time=12'h200; strike_count=0.
2. RUNNING with digits held {0,0,0} during the first GUARD_CYCLES cycles → state stays 8'h10. Digits still zero after guard expires → 8'h30 next cycle.
3. RUNNING, MAX_STRIKES=3: strike=4'b0001, then 4'b0110 in one cycle → strike_count 1 then 3; game_state=8'h30 on the next cycle; further strikes leave the count at 3.
4. RUNNING: assert solved bits 0..3 one at a time, releasing each after 1 cycle → solved_mask accumulates to 4'hF; game_state=8'h20 one cycle after the last bit.
5. Same cycle: solved completes the mask and a strike reaches MAX_STRIKES → game_state=8'h30, not 8'h20.
6. From 8'h20, pulse start → 8'h00 next cycle (init_time unchanged). Second start with time_sel=11 → 8'h10 and init_time=12'h060. Drop reset mid-RUNNING → 8'h00 and all counters cleared on that edge.

Source files
------------

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//   Top-level game controller. Runs the IDLE -> RUNNING -> DEFUSED/EXPLODED
//   flow. It latches the initial BCD time and accumulates strikes and solved
//   flags. It also decides the outcome from the timer digits. Every output is
//   registered.
//
// State table:
//   S_IDLE     | waiting for start; game_state = 8'h00
//   S_RUNNING  | game in progress; game_state = 8'h10
//   S_DEFUSED  | all modules solved; game_state = 8'h20
//   S_EXPLODED | strikes exhausted or timer hit zero; game_state = 8'h30
//
// Ports:
//   clk          : system clock
//   reset        : synchronous, active-low reset
//   start        : single-cycle pulse; starts a game or leaves an end state
//   time_sel     : difficulty select, sampled on start in IDLE
//   value_three  : timer BCD hundreds digit
//   value_two    : timer BCD tens digit
//   value_one    : timer BCD units digit
//   solved       : per-module solved level
//   strike       : per-module single-cycle strike pulse
//   game_state   : state code for the timer and the puzzle modules
//   init_time    : BCD {hundreds, tens, units} initial time
//   strike_count : accumulated strikes (saturates at 15)
//   solved_mask  : sticky per-module solved flags
// -----------------------------------------------------------------------------
module game_sequencer #(
    parameter int NUM_MODULES  = 4,
    parameter int MAX_STRIKES  = 3,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             time_sel,
    input  logic [3:0]             value_three,
    input  logic [3:0]             value_two,
    input  logic [3:0]             value_one,
    input  logic [NUM_MODULES-1:0] solved,
    input  logic [NUM_MODULES-1:0] strike,
    output logic [7:0]             game_state,
    output logic [11:0]            init_time,
    output logic [3:0]             strike_count,
    output logic [NUM_MODULES-1:0] solved_mask
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUNNING  = 2'd1,
        S_DEFUSED  = 2'd2,
        S_EXPLODED = 2'd3
    } state_t;

    state_t                 r_state;
    logic [7:0]             r_game_state;
    logic [11:0]            r_init_time;
    logic [3:0]             r_strike_count;
    logic [NUM_MODULES-1:0] r_solved_mask;
    logic [GW-1:0]          r_guard;

    state_t                 w_state_next;
    logic [7:0]             w_game_state_next;
    logic [11:0]            w_init_time_next;
    logic [3:0]             w_strike_count_next;
    logic [NUM_MODULES-1:0] w_solved_mask_next;
    logic [GW-1:0]          w_guard_next;

    logic [3:0]             w_pop;
    logic [4:0]             w_strike_sum;
    logic [3:0]             w_strike_upd;
    logic [NUM_MODULES-1:0] w_solved_upd;
    logic                   w_timer_zero;

    // Running values for this cycle: the exit decision looks at these,
    // not at the registered copies.
    always_comb begin
        w_pop = 4'd0;
        for (int i = 0; i < NUM_MODULES; i++) begin
            w_pop = w_pop + 4'(strike[i]);
        end
        w_strike_sum = {1'b0, r_strike_count} + {1'b0, w_pop};
        w_strike_upd = (w_strike_sum > 5'd15) ? 4'd15 : w_strike_sum[3:0];
        w_solved_upd = r_solved_mask | solved;
        w_timer_zero = (value_three == 4'd0) && (value_two == 4'd0) &&
                       (value_one == 4'd0);
    end

    always_comb begin
        w_state_next        = r_state;
        w_init_time_next    = r_init_time;
        w_strike_count_next = r_strike_count;
        w_solved_mask_next  = r_solved_mask;
        w_guard_next        = r_guard;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (time_sel)
                        2'b00:   w_init_time_next = 12'h300;
                        2'b01:   w_init_time_next = 12'h200;
                        2'b10:   w_init_time_next = 12'h100;
                        default: w_init_time_next = 12'h060;
                    endcase
                    w_strike_count_next = 4'd0;
                    w_solved_mask_next  = '0;
                    w_guard_next        = GW'(GUARD_CYCLES);
                    w_state_next        = S_RUNNING;
                end
            end
            S_RUNNING: begin
                w_guard_next        = (r_guard != '0) ? r_guard - 1'b1 : '0;
                w_strike_count_next = w_strike_upd;
                w_solved_mask_next  = w_solved_upd;
                // The zero check uses the guard held this cycle, so the
                // first GUARD_CYCLES running cycles never see the timer
                // digits while the timer is still loading.
                if (w_strike_upd >= 4'(MAX_STRIKES)) begin
                    w_state_next = S_EXPLODED;
                end else if ((r_guard == '0) && w_timer_zero) begin
                    w_state_next = S_EXPLODED;
                end else if (&w_solved_upd) begin
                    w_state_next = S_DEFUSED;
                end
            end
            S_DEFUSED, S_EXPLODED: begin
                if (start) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        case (w_state_next)
            S_RUNNING:  w_game_state_next = 8'h10;
            S_DEFUSED:  w_game_state_next = 8'h20;
            S_EXPLODED: w_game_state_next = 8'h30;
            default:    w_game_state_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_game_state   <= 8'h00;
            r_init_time    <= 12'h300;
            r_strike_count <= 4'd0;
            r_solved_mask  <= '0;
            r_guard        <= '0;
        end else begin
            r_state        <= w_state_next;
            r_game_state   <= w_game_state_next;
            r_init_time    <= w_init_time_next;
            r_strike_count <= w_strike_count_next;
            r_solved_mask  <= w_solved_mask_next;
            r_guard        <= w_guard_next;
        end
    end

    assign game_state   = r_game_state;
    assign init_time    = r_init_time;
    assign strike_count = r_strike_count;
    assign solved_mask  = r_solved_mask;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

    localparam int NM = 4;
    localparam int MS = 3;
    localparam int GC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    time_sel;
    logic [3:0]    value_three;
    logic [3:0]    value_two;
    logic [3:0]    value_one;
    logic [NM-1:0] solved;
    logic [NM-1:0] strike;
    logic [7:0]    game_state;
    logic [11:0]   init_time;
    logic [3:0]    strike_count;
    logic [NM-1:0] solved_mask;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: phase is the expected game_state code.
    logic [7:0]  m_phase;
    logic [11:0] m_init;
    int          m_strikes;
    logic [NM-1:0] m_mask;
    int          m_run;

    game_sequencer #(
        .NUM_MODULES (NM),
        .MAX_STRIKES (MS),
        .GUARD_CYCLES(GC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .time_sel    (time_sel),
        .value_three (value_three),
        .value_two   (value_two),
        .value_one   (value_one),
        .solved      (solved),
        .strike      (strike),
        .game_state  (game_state),
        .init_time   (init_time),
        .strike_count(strike_count),
        .solved_mask (solved_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [11:0] exp_init;
    } sel_vec_t;

    sel_vec_t vecs [4];

    function automatic logic [11:0] sel_to_time(input logic [1:0] s);
        logic [11:0] t [4];
        t[0] = 12'h300;
        t[1] = 12'h200;
        t[2] = 12'h100;
        t[3] = 12'h060;
        return t[s];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        if (!reset) begin
            m_phase   = 8'h00;
            m_init    = 12'h300;
            m_strikes = 0;
            m_mask    = '0;
            m_run     = 0;
        end else begin
            case (m_phase)
                8'h00: begin
                    if (start) begin
                        m_init    = sel_to_time(time_sel);
                        m_strikes = 0;
                        m_mask    = '0;
                        m_run     = 0;
                        m_phase   = 8'h10;
                    end
                end
                8'h10: begin
                    m_run++;
                    m_strikes = m_strikes + $countones(strike);
                    if (m_strikes > 15) m_strikes = 15;
                    m_mask = m_mask | solved;
                    if (m_strikes >= MS)
                        m_phase = 8'h30;
                    else if (m_run > GC && value_three == 0 && value_two == 0 && value_one == 0)
                        m_phase = 8'h30;
                    else if (m_mask == {NM{1'b1}})
                        m_phase = 8'h20;
                end
                default: begin
                    if (start) m_phase = 8'h00;
                end
            endcase
        end
    endtask

    // One clock: model consumes the inputs seen at this edge, then the DUT
    // outputs are compared just after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model game_state", 32'(game_state), 32'(m_phase));
        check("model init_time", 32'(init_time), 32'(m_init));
        check("model strike_count", 32'(strike_count), 32'(m_strikes));
        check("model solved_mask", 32'(solved_mask), 32'(m_mask));
    endtask

    task automatic pulse_start(input logic [1:0] sel);
        time_sel = sel;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        time_sel    = 2'b00;
        value_three = 4'd3;
        value_two   = 4'd0;
        value_one   = 4'd0;
        solved      = '0;
        strike      = '0;

        vecs[0] = '{sel: 2'b00, exp_init: 12'h300};
        vecs[1] = '{sel: 2'b01, exp_init: 12'h200};
        vecs[2] = '{sel: 2'b10, exp_init: 12'h100};
        vecs[3] = '{sel: 2'b11, exp_init: 12'h060};

        // Reset state.
        tick();
        tick();
        check("reset game_state", 32'(game_state), 32'h00);
        check("reset init_time", 32'(init_time), 32'h300);
        check("reset strike_count", 32'(strike_count), 32'd0);
        check("reset solved_mask", 32'(solved_mask), 32'd0);
        reset = 1'b1;

        // Start with time_sel=01.
        tick();
        check("idle before start", 32'(game_state), 32'h00);
        pulse_start(2'b01);
        check("start game_state", 32'(game_state), 32'h10);
        check("start init_time", 32'(init_time), 32'h200);
        check("start strike_count", 32'(strike_count), 32'd0);

        // Timer-zero guard.
        value_three = 4'd0;
        for (int i = 0; i < GC; i++) begin
            tick();
            check("guard masks zero", 32'(game_state), 32'h10);
        end
        tick();
        check("zero after guard", 32'(game_state), 32'h30);
        value_three = 4'd2;
        pulse_start(2'b00);
        check("exploded to idle", 32'(game_state), 32'h00);

        // Strike accumulation.
        pulse_start(2'b00);
        strike = 4'b0001;
        tick();
        check("one strike", 32'(strike_count), 32'd1);
        check("one strike state", 32'(game_state), 32'h10);
        strike = 4'b0110;
        tick();
        check("two strikes same cycle", 32'(strike_count), 32'd3);
        check("max strikes explode", 32'(game_state), 32'h30);
        strike = 4'b1111;
        tick();
        check("strikes frozen", 32'(strike_count), 32'd3);
        strike = '0;
        pulse_start(2'b00);

        // Solved bits one at a time.
        pulse_start(2'b10);
        for (int i = 0; i < NM; i++) begin
            solved = NM'(1) << i;
            tick();
            solved = '0;
            check("solved mask grows", 32'(solved_mask), 32'((1 << (i + 1)) - 1));
            check("solved state", 32'(game_state), (i == NM - 1) ? 32'h20 : 32'h10);
        end
        tick();
        check("defused holds", 32'(game_state), 32'h20);
        pulse_start(2'b11);
        check("defused to idle", 32'(game_state), 32'h00);
        check("init_time held", 32'(init_time), 32'h100);
        pulse_start(2'b11);
        check("restart state", 32'(game_state), 32'h10);
        check("restart init_time", 32'(init_time), 32'h060);

        // Explosion beats defusal in the same cycle.
        strike = 4'b0011;
        tick();
        strike = '0;
        solved = 4'b0111;
        tick();
        solved = 4'b1000;
        strike = 4'b0001;
        tick();
        solved = '0;
        strike = '0;
        check("explode beats defuse", 32'(game_state), 32'h30);

        // Reset mid-game.
        pulse_start(2'b00);
        pulse_start(2'b01);
        strike = 4'b0001;
        solved = 4'b0001;
        tick();
        strike = '0;
        solved = '0;
        check("pre-reset running", 32'(game_state), 32'h10);
        reset = 1'b0;
        tick();
        check("midgame reset state", 32'(game_state), 32'h00);
        check("midgame reset strikes", 32'(strike_count), 32'd0);
        check("midgame reset mask", 32'(solved_mask), 32'd0);
        check("midgame reset init", 32'(init_time), 32'h300);
        reset = 1'b1;

        // Decode table.
        for (int i = 0; i < 4; i++) begin
            pulse_start(vecs[i].sel);
            check("decode init_time", 32'(init_time), 32'(vecs[i].exp_init));
            reset = 1'b0;
            tick();
            reset = 1'b1;
        end

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 199) != 0);
            start    = ($urandom_range(0, 9) == 0);
            time_sel = 2'($urandom_range(0, 3));
            for (int b = 0; b < NM; b++) begin
                strike[b] = ($urandom_range(0, 19) == 0);
                solved[b] = ($urandom_range(0, 5) == 0);
            end
            if ($urandom_range(0, 29) == 0) begin
                value_three = 4'd0;
                value_two   = 4'd0;
                value_one   = 4'd0;
            end else begin
                value_three = 4'($urandom_range(0, 9));
                value_two   = 4'($urandom_range(0, 9));
                value_one   = 4'($urandom_range(1, 9));
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
